// File: rtl/uart_port_pkg.sv
// Shared types and constants for the CPLD UART port controller.
// Holds the FSM state encoding, default timing constants and FIFO count sizing.
package uart_port_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_STB  = 3'd2,
    WR_REQ  = 3'd3,
    WR_STB  = 3'd4,
    WR_REL  = 3'd5,
    WR_TBRE = 3'd6,
    WR_TSRE = 3'd7
  } uart_state_t;

  localparam int DEFAULT_PULSE_CYC   = 2;
  localparam int DEFAULT_TIMEOUT_CYC = 1024;

  // Occupancy counters need one extra bit so "full" is distinguishable from "empty".
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_port_ctrl_if.sv
// CPU-side character streams of the UART port controller, plus status and error flag.
// Both streams are valid/ready: a transfer happens in any cycle where valid and ready are both 1;
// valid never waits on ready, and ready reflects only FIFO fullness (tx) or the consumer (rx).
interface uart_port_ctrl_if #(
  parameter int DATA_W   = 16,
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4
);
  import uart_port_pkg::*;

  localparam int RX_CW = count_w(RX_DEPTH);
  localparam int TX_CW = count_w(TX_DEPTH);

  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic [RX_CW-1:0]  rx_count;
  logic [TX_CW-1:0]  tx_count;
  logic              tx_err;
  logic              err_clr;

  modport master (
    output tx_valid, tx_data, rx_ready, err_clr,
    input  tx_ready, rx_valid, rx_data, rx_count, tx_count, tx_err
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready, err_clr,
    output tx_ready, rx_valid, rx_data, rx_count, tx_count, tx_err
  );

endinterface

// File: rtl/uart_port_ctrl_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is dropped when full, pop ignored when empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo import uart_port_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [count_w(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_port_ctrl.sv
// Controller for the CPLD UART sharing Ram1Data: buffers characters in FIFOs, arbitrates
// for the bus via req/gnt, generates rdn/wrn strobes and times out stalled transmissions.
module uart_port_ctrl import uart_port_pkg::*; #(
  parameter int DATA_W      = 16,
  parameter int CHAR_W      = 8,
  parameter int RX_DEPTH    = 4,
  parameter int TX_DEPTH    = 4,
  parameter int PULSE_CYC   = DEFAULT_PULSE_CYC,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               rst,
  uart_port_ctrl_if.slave    cpu,
  output logic               bus_req,
  input  logic               bus_gnt,
  output logic               bus_oe,
  output logic [DATA_W-1:0]  bus_dout,
  input  logic [DATA_W-1:0]  bus_din,
  output logic               rdn,
  output logic               wrn,
  input  logic               data_ready,
  input  logic               tbre,
  input  logic               tsre,
  output uart_state_t        state_dbg
);

  localparam int CNT_MAX = (TIMEOUT_CYC > PULSE_CYC) ? TIMEOUT_CYC : PULSE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  uart_state_t       state, next_state;
  logic [CNT_W-1:0]  cyc_cnt;
  logic              rx_push, rx_full, rx_empty;
  logic              tx_pop, tx_full, tx_empty;
  logic              tmo_hit;
  logic              tx_err_q;
  logic [CHAR_W-1:0] rx_head, tx_head;
  logic              unused_hi;

  sync_fifo #(.WIDTH(CHAR_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (bus_din[CHAR_W-1:0]),
    .pop   (cpu.rx_ready),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (cpu.rx_count)
  );

  sync_fifo #(.WIDTH(CHAR_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu.tx_valid),
    .din   (cpu.tx_data[CHAR_W-1:0]),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (cpu.tx_count)
  );

  assign cpu.tx_ready = !tx_full;
  assign cpu.rx_valid = !rx_empty;
  assign cpu.rx_data  = DATA_W'(rx_head);
  assign cpu.tx_err   = tx_err_q;
  assign state_dbg    = state;
  assign unused_hi    = ^{bus_din, cpu.tx_data};

  always_comb begin
    next_state = state;
    rx_push    = 1'b0;
    tx_pop     = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        // Receive wins; a full rx FIFO leaves the character waiting in the UART.
        if (data_ready && !rx_full) next_state = RD_REQ;
        else if (!tx_empty)         next_state = WR_REQ;
      end
      RD_REQ: if (bus_gnt) next_state = RD_STB;
      RD_STB: begin
        if (cyc_cnt == PULSE_LAST) begin
          rx_push    = 1'b1;
          next_state = IDLE;
        end
      end
      WR_REQ: if (bus_gnt) next_state = WR_STB;
      WR_STB: begin
        tx_pop = (cyc_cnt == '0);
        if (cyc_cnt == PULSE_LAST) next_state = WR_REL;
      end
      WR_REL: next_state = WR_TBRE;
      WR_TBRE: begin
        if (tbre) next_state = WR_TSRE;
        else if (cyc_cnt >= TMO_LAST) begin
          tmo_hit    = 1'b1;
          next_state = IDLE;
        end
      end
      WR_TSRE: begin
        if (tsre) next_state = IDLE;
        else if (cyc_cnt >= TMO_LAST) begin
          tmo_hit    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes and bus controls are registered from next_state so they are glitch-free pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      rdn      <= 1'b1;
      wrn      <= 1'b1;
      bus_req  <= 1'b0;
      bus_oe   <= 1'b0;
      bus_dout <= '0;
      tx_err_q <= 1'b0;
    end else begin
      state   <= next_state;
      rdn     <= (next_state != RD_STB);
      wrn     <= (next_state != WR_STB);
      bus_req <= next_state inside {RD_REQ, RD_STB, WR_REQ, WR_STB, WR_REL};
      bus_oe  <= next_state inside {WR_STB, WR_REL};
      // One counter times strobes and the whole tbre+tsre wait window.
      if (next_state != state && !(state == WR_TBRE && next_state == WR_TSRE))
        cyc_cnt <= '0;
      else
        cyc_cnt <= cyc_cnt + 1'b1;
      if (state == WR_REQ && bus_gnt) bus_dout <= DATA_W'(tx_head);
      if (tmo_hit)          tx_err_q <= 1'b1;
      else if (cpu.err_clr) tx_err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_port_ctrl.sv
// Directed bench for uart_port_ctrl: reset, receive, transmit, overflow, priority with
// delayed grant, timeout with error clear, and reset during a write strobe.
module tb_uart_port_ctrl;
  import uart_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req, bus_gnt, bus_oe;
  logic [15:0] bus_dout, bus_din;
  logic        rdn, wrn, data_ready, tbre, tsre;
  uart_state_t dut_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int lows;

  uart_port_ctrl_if #(.DATA_W(16), .RX_DEPTH(4), .TX_DEPTH(4)) cpu ();

  uart_port_ctrl #(
    .DATA_W(16), .CHAR_W(8), .RX_DEPTH(4), .TX_DEPTH(4),
    .PULSE_CYC(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_oe     (bus_oe),
    .bus_dout   (bus_dout),
    .bus_din    (bus_din),
    .rdn        (rdn),
    .wrn        (wrn),
    .data_ready (data_ready),
    .tbre       (tbre),
    .tsre       (tsre),
    .state_dbg  (dut_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Driver and checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input uart_state_t tgt, input int budget, input string tag);
    int i = 0;
    while (dut_state != tgt && i < budget) begin
      step();
      i++;
    end
    chk(tag, 32'(dut_state), 32'(tgt));
  endtask

  initial begin
    rst = 1'b1; bus_gnt = 1'b0; bus_din = '0; data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
    cpu.tx_valid = 1'b0; cpu.tx_data = '0; cpu.rx_ready = 1'b0; cpu.err_clr = 1'b0;

    // Reset
    step(); step();
    chk("rst_rdn", rdn, 1);
    chk("rst_wrn", wrn, 1);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_oe", bus_oe, 0);
    chk("rst_bus_dout", bus_dout, 0);
    chk("rst_tx_ready", cpu.tx_ready, 1);
    chk("rst_rx_valid", cpu.rx_valid, 0);
    chk("rst_counts", {cpu.rx_count, cpu.tx_count}, 0);
    chk("rst_tx_err", cpu.tx_err, 0);
    chk("rst_state", 32'(dut_state), 32'(IDLE));
    rst = 1'b0;

    // Receive path
    bus_gnt = 1'b1; bus_din = 16'hAB5A; data_ready = 1'b1;
    step();
    chk("rd_req_state", 32'(dut_state), 32'(RD_REQ));
    chk("rd_req_bus_req", bus_req, 1);
    chk("rd_req_rdn", rdn, 1);
    data_ready = 1'b0;
    step(); chk("rd_stb1_rdn", rdn, 0);
    step(); chk("rd_stb2_rdn", rdn, 0);
    chk("rd_stb2_rx_valid", cpu.rx_valid, 0);
    step();
    chk("rd_end_rdn", rdn, 1);
    chk("rd_end_bus_req", bus_req, 0);
    chk("rd_rx_data", cpu.rx_data, 16'h005A);
    chk("rd_rx_count", cpu.rx_count, 1);
    chk("rd_end_state", 32'(dut_state), 32'(IDLE));
    cpu.rx_ready = 1'b1; step(); cpu.rx_ready = 1'b0;
    chk("rd_pop_count", cpu.rx_count, 0);

    // Transmit path
    cpu.tx_valid = 1'b1; cpu.tx_data = 16'h0041;
    step(); cpu.tx_valid = 1'b0;
    chk("wr_push_count", cpu.tx_count, 1);
    step(); chk("wr_req_state", 32'(dut_state), 32'(WR_REQ));
    chk("wr_req_bus_req", bus_req, 1);
    step();
    chk("wr_stb1_wrn", wrn, 0);
    chk("wr_stb1_oe", bus_oe, 1);
    chk("wr_stb1_dout", bus_dout, 16'h0041);
    step();
    chk("wr_stb2_wrn", wrn, 0);
    chk("wr_pop_count", cpu.tx_count, 0);
    step();
    chk("wr_rel_wrn", wrn, 1);
    chk("wr_rel_oe", bus_oe, 1);
    step();
    chk("wr_tbre_oe", bus_oe, 0);
    chk("wr_tbre_bus_req", bus_req, 0);
    chk("wr_tbre_state", 32'(dut_state), 32'(WR_TBRE));
    step();
    tbre = 1'b1; step();
    chk("wr_tsre_state", 32'(dut_state), 32'(WR_TSRE));
    step();
    chk("wr_tsre_hold", 32'(dut_state), 32'(WR_TSRE));
    tsre = 1'b1; step();
    chk("wr_done_state", 32'(dut_state), 32'(IDLE));
    chk("wr_done_err", cpu.tx_err, 0);
    tbre = 1'b0; tsre = 1'b0;

    // Receive overflow: four reads fill the FIFO, the fifth waits in the UART
    data_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus_din = 16'hA530 + 16'(r);
      repeat (4) step();
    end
    chk("ovf_rx_count", cpu.rx_count, 4);
    chk("ovf_tx_ready", cpu.tx_ready, 1);
    lows = 0;
    repeat (8) begin
      step();
      if (rdn !== 1'b1) lows++;
    end
    chk("ovf_no_fifth_read", lows, 0);
    chk("ovf_rx_count_hold", cpu.rx_count, 4);
    data_ready = 1'b0;
    cpu.rx_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      chk("ovf_rx_order", cpu.rx_data, 32'h30 + r);
      step();
    end
    cpu.rx_ready = 1'b0;
    chk("ovf_drained", cpu.rx_valid, 0);

    // Priority with delayed grant
    cpu.tx_valid = 1'b1; cpu.tx_data = 16'h0042; bus_gnt = 1'b0;
    step(); cpu.tx_valid = 1'b0;
    data_ready = 1'b1; bus_din = 16'h7E61;
    step();
    chk("pri_read_first", 32'(dut_state), 32'(RD_REQ));
    data_ready = 1'b0;
    lows = 0;
    repeat (4) begin
      step();
      if (rdn !== 1'b1 || dut_state != RD_REQ) lows++;
    end
    chk("pri_gnt_wait", lows, 0);
    bus_gnt = 1'b1;
    step(); chk("pri_rd_stb", rdn, 0);
    step(); step();
    chk("pri_rd_done", 32'(dut_state), 32'(IDLE));
    chk("pri_rx_data", cpu.rx_data, 16'h0061);
    step(); chk("pri_wr_next", 32'(dut_state), 32'(WR_REQ));
    step();
    chk("pri_wr_stb", wrn, 0);
    chk("pri_wr_dout", bus_dout, 16'h0042);
    tbre = 1'b1; tsre = 1'b1;
    wait_state(IDLE, 20, "pri_wr_done");
    cpu.rx_ready = 1'b1; step(); cpu.rx_ready = 1'b0;
    tbre = 1'b0; tsre = 1'b0;

    // Timeout: tbre never rises; set and clear in the same cycle keeps the flag
    cpu.tx_valid = 1'b1; cpu.tx_data = 16'h0055;
    step(); cpu.tx_valid = 1'b0;
    wait_state(WR_TBRE, 20, "tmo_enter");
    repeat (15) step();
    chk("tmo_not_yet", cpu.tx_err, 0);
    chk("tmo_still_wait", 32'(dut_state), 32'(WR_TBRE));
    cpu.err_clr = 1'b1;
    step();
    chk("tmo_set_wins", cpu.tx_err, 1);
    chk("tmo_idle", 32'(dut_state), 32'(IDLE));
    chk("tmo_tx_count", cpu.tx_count, 0);
    step();
    chk("tmo_cleared", cpu.tx_err, 0);
    cpu.err_clr = 1'b0;

    // Reset during a write strobe discards everything
    tbre = 1'b1; tsre = 1'b1; data_ready = 1'b1;
    step(); data_ready = 1'b0;
    wait_state(IDLE, 10, "rst_rx_done");
    chk("rst_rx_buffered", cpu.rx_count, 1);
    cpu.tx_valid = 1'b1; cpu.tx_data = 16'h0066;
    step(); cpu.tx_data = 16'h0067;
    step(); cpu.tx_valid = 1'b0;
    wait_state(WR_STB, 10, "rst_in_wr_stb");
    chk("rst_pre_wrn", wrn, 0);
    rst = 1'b1;
    step();
    chk("rst_mid_wrn", wrn, 1);
    chk("rst_mid_oe", bus_oe, 0);
    chk("rst_mid_bus_req", bus_req, 0);
    chk("rst_mid_tx_count", cpu.tx_count, 0);
    chk("rst_mid_rx_count", cpu.rx_count, 0);
    chk("rst_mid_state", 32'(dut_state), 32'(IDLE));
    rst = 1'b0;
    step();
    chk("rst_after_idle", 32'(dut_state), 32'(IDLE));
    chk("rst_after_tx_ready", cpu.tx_ready, 1);

    // Report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
